fb_access_ctrl: RTL

//   Owns the processor-side (port A) of the character frame buffer and shares it between two requesters:
//   the CPU/AXI-slave register path and a hardware clear engine.
//   - The clear engine fills every character cell with one 16-bit word: R3/G3/B3 colour plus 7-bit character code.
//   - The block issues one frame-buffer access per clock and drives the buffer's address/data/write-enable directly.
//   - It returns CPU read data, matching the buffer's 1-cycle registered read.

---
 rtl/fb_access_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fb_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fb_access_ctrl
// Brief   : Port-A owner of the character frame buffer; arbitrates CPU
//           accesses against a hardware fill (clear) engine, one access/clock.
// Revision: 1.0  initial release
// ============================================================================
module fb_access_ctrl #(
    parameter int ADDR_WIDTH    = 13,
    parameter int ALL_CHAR_SIZE = 7500
) (
    input  logic                  clka,
    input  logic                  reset_a_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [15:0]           cpu_wdata,
    output logic                  cpu_ack,
    output logic [15:0]           cpu_rdata,
    output logic                  cpu_rvalid,
    input  logic                  clr_start,
    input  logic [15:0]           clr_value,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [15:0]           fb_din,
    output logic                  fb_we,
    input  logic [15:0]           fb_dout
);

    localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(ALL_CHAR_SIZE - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
    logic [15:0]             clr_val_q, clr_val_nxt;
    logic [ADDR_WIDTH-1:0]   fb_addr_nxt;
    logic [15:0]             fb_din_nxt;
    logic                    fb_we_nxt;
    logic                    cpu_ack_nxt;
    logic                    busy_nxt;
    logic                    done_nxt;
    logic                    rd_issue_nxt;
    logic                    rd_p1;
    logic                    rd_p2;
    logic                    cpu_grant;

    // The ack cycle never re-samples the request, so the CPU gets at most every other slot.
    assign cpu_grant = cpu_req & ~cpu_ack;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        clr_val_nxt  = clr_val_q;
        fb_addr_nxt  = fb_addr;
        fb_din_nxt   = fb_din;
        fb_we_nxt    = 1'b0;
        cpu_ack_nxt  = 1'b0;
        busy_nxt     = clr_busy;
        done_nxt     = 1'b0;
        rd_issue_nxt = 1'b0;

        if (cpu_grant) begin
            fb_addr_nxt  = cpu_addr;
            fb_din_nxt   = cpu_wdata;
            fb_we_nxt    = cpu_we;
            cpu_ack_nxt  = 1'b1;
            rd_issue_nxt = ~cpu_we;
        end

        case (state)
            ST_IDLE: begin
                if (clr_start) begin
                    state_nxt   = ST_CLEAR;
                    clr_val_nxt = clr_value;
                    cnt_nxt     = '0;
                    busy_nxt    = 1'b1;
                end
            end
            ST_CLEAR: begin
                // The fill only advances in slots the CPU leaves free.
                if (!cpu_grant) begin
                    fb_addr_nxt = cnt;
                    fb_din_nxt  = clr_val_q;
                    fb_we_nxt   = 1'b1;
                    if (cnt == LAST_CELL) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clka or negedge reset_a_n) begin
        if (!reset_a_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            clr_val_q <= '0;
            fb_addr   <= '0;
            fb_din    <= '0;
            fb_we     <= 1'b0;
            cpu_ack   <= 1'b0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            clr_val_q <= clr_val_nxt;
            fb_addr   <= fb_addr_nxt;
            fb_din    <= fb_din_nxt;
            fb_we     <= fb_we_nxt;
            cpu_ack   <= cpu_ack_nxt;
            clr_busy  <= busy_nxt;
            clr_done  <= done_nxt;
        end
    end

    // Read return: buffer captures the address one edge after grant, data is registered here on the next.
    always_ff @(posedge clka or negedge reset_a_n) begin
        if (!reset_a_n) begin
            rd_p1      <= 1'b0;
            rd_p2      <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            rd_p1      <= rd_issue_nxt;
            rd_p2      <= rd_p1;
            cpu_rvalid <= rd_p2;
            if (rd_p2) begin
                cpu_rdata <= fb_dout;
            end
        end
    end

endmodule
`default_nettype wire
